// File: rtl/pong_pkg.sv
// Shared types, default playfield geometry and helpers for the pong game engine.
package pong_pkg;

    typedef enum logic [1:0] {
        SERVE     = 2'd0,
        PLAY      = 2'd1,
        POINT     = 2'd2,
        GAME_OVER = 2'd3
    } game_state_t;

    localparam int DEF_SCREEN_W        = 640;
    localparam int DEF_SCREEN_H        = 480;
    localparam int DEF_BALL_SIZE       = 25;
    localparam int DEF_PADDLE_W        = 10;
    localparam int DEF_PADDLE_H        = 150;
    localparam int DEF_PADDLE_L_X      = 40;
    localparam int DEF_PADDLE_R_X      = 600;
    localparam int DEF_PADDLE_VEL      = 6;
    localparam int DEF_BALL_SPEED_INIT = 4;
    localparam int DEF_BALL_SPEED_MAX  = 12;
    localparam int DEF_SCORE_MAX       = 9;
    localparam int DEF_PAUSE_TICKS     = 60;

    function automatic int clamp(input int v, input int lo, input int hi);
        int r;
        r = v;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle: vertical position register stepped by up/down buttons on enabled ticks.
module pong_paddle
    import pong_pkg::*;
#(
    parameter int PADDLE_H   = DEF_PADDLE_H,
    parameter int PADDLE_VEL = DEF_PADDLE_VEL,
    parameter int SCREEN_H   = DEF_SCREEN_H
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        enable_i,
    input  logic                        up_i,
    input  logic                        down_i,
    output logic [$clog2(SCREEN_H)-1:0] pos_o
);

    localparam int YW      = $clog2(SCREEN_H);
    localparam int POS_MAX = SCREEN_H - PADDLE_H;
    localparam logic [YW-1:0] POS_RESET = YW'((SCREEN_H - PADDLE_H) / 2);

    logic [YW-1:0] pos_q, pos_d;
    int            step;

    // Pressing both buttons cancels out, same as pressing neither.
    always_comb begin
        step  = 0;
        pos_d = pos_q;
        if (up_i && !down_i) begin
            step = -PADDLE_VEL;
        end else if (down_i && !up_i) begin
            step = PADDLE_VEL;
        end
        if (enable_i) begin
            pos_d = YW'(clamp(int'(pos_q) + step, 0, POS_MAX));
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pos_q <= POS_RESET;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/pong_game_engine.sv
// Pong game state: ball physics, paddle bounces, scoring and serve/point/game-over sequencing.
module pong_game_engine
    import pong_pkg::*;
#(
    parameter int SCREEN_W        = DEF_SCREEN_W,
    parameter int SCREEN_H        = DEF_SCREEN_H,
    parameter int BALL_SIZE       = DEF_BALL_SIZE,
    parameter int PADDLE_W        = DEF_PADDLE_W,
    parameter int PADDLE_H        = DEF_PADDLE_H,
    parameter int PADDLE_L_X      = DEF_PADDLE_L_X,
    parameter int PADDLE_R_X      = DEF_PADDLE_R_X,
    parameter int PADDLE_VEL      = DEF_PADDLE_VEL,
    parameter int BALL_SPEED_INIT = DEF_BALL_SPEED_INIT,
    parameter int BALL_SPEED_MAX  = DEF_BALL_SPEED_MAX,
    parameter int SCORE_MAX       = DEF_SCORE_MAX,
    parameter int PAUSE_TICKS     = DEF_PAUSE_TICKS
) (
    input  logic                        pixel_clk,
    input  logic                        reset,
    input  logic                        frame_tick,
    input  logic                        serve,
    input  logic                        l_up,
    input  logic                        l_down,
    input  logic                        r_up,
    input  logic                        r_down,
    output logic [$clog2(SCREEN_W)-1:0] ball_x,
    output logic [$clog2(SCREEN_H)-1:0] ball_y,
    output logic [$clog2(SCREEN_H)-1:0] paddle_l_y,
    output logic [$clog2(SCREEN_H)-1:0] paddle_r_y,
    output logic [3:0]                  score_l,
    output logic [3:0]                  score_r,
    output logic [1:0]                  state,
    output logic                        hit_pulse,
    output logic                        point_pulse,
    output logic                        game_over
);

    localparam int XW = $clog2(SCREEN_W);
    localparam int YW = $clog2(SCREEN_H);
    localparam int VW = ((XW > YW) ? XW : YW) + 2;
    localparam int PW = $clog2(PAUSE_TICKS + 1);

    localparam logic [XW-1:0]        X_CTR  = XW'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [YW-1:0]        Y_CTR  = YW'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic signed [VW-1:0] V_INIT = VW'(BALL_SPEED_INIT);
    localparam logic signed [VW-1:0] V_MAX  = VW'(BALL_SPEED_MAX);
    localparam logic signed [VW-1:0] V_ONE  = VW'(1);
    localparam logic signed [VW-1:0] ZERO   = '0;
    localparam logic signed [VW-1:0] L_FACE = VW'(PADDLE_L_X + PADDLE_W);
    localparam logic signed [VW-1:0] R_FACE = VW'(PADDLE_R_X - BALL_SIZE);
    localparam logic signed [VW-1:0] X_MAX  = VW'(SCREEN_W - BALL_SIZE);
    localparam logic signed [VW-1:0] Y_MAX  = VW'(SCREEN_H - BALL_SIZE);
    localparam logic [PW-1:0]        PAUSE_LAST = PW'(PAUSE_TICKS - 1);
    localparam logic [3:0]           S_MAX  = 4'(SCORE_MAX);

    game_state_t            state_q, state_d;
    logic [XW-1:0]          ballX_q, ballX_d;
    logic [YW-1:0]          ballY_q, ballY_d;
    logic signed [VW-1:0]   vx_q, vx_d;
    logic signed [VW-1:0]   vy_q, vy_d;
    logic [3:0]             scoreL_q, scoreL_d;
    logic [3:0]             scoreR_q, scoreR_d;
    logic                   lastLeft_q, lastLeft_d;
    logic [PW-1:0]          pauseCnt_q, pauseCnt_d;
    logic                   hitPulse_q, hitPulse_d;
    logic                   pointPulse_q, pointPulse_d;

    logic [YW-1:0]          padL, padR;
    logic                   padEnable;
    logic signed [VW-1:0]   nx, ny, absVx, absVy, boost;
    logic                   overlapL, overlapR;

    assign padEnable = frame_tick && (state_q == SERVE || state_q == PLAY);

    pong_paddle #(
        .PADDLE_H   (PADDLE_H),
        .PADDLE_VEL (PADDLE_VEL),
        .SCREEN_H   (SCREEN_H)
    ) u_paddleL (
        .clk_i    (pixel_clk),
        .reset_i  (reset),
        .enable_i (padEnable),
        .up_i     (l_up),
        .down_i   (l_down),
        .pos_o    (padL)
    );

    pong_paddle #(
        .PADDLE_H   (PADDLE_H),
        .PADDLE_VEL (PADDLE_VEL),
        .SCREEN_H   (SCREEN_H)
    ) u_paddleR (
        .clk_i    (pixel_clk),
        .reset_i  (reset),
        .enable_i (padEnable),
        .up_i     (r_up),
        .down_i   (r_down),
        .pos_o    (padR)
    );

    // Positions are zero-extended into the wider signed velocity width so edge tests never wrap.
    always_comb begin
        nx       = $signed({{(VW-XW){1'b0}}, ballX_q}) + vx_q;
        ny       = $signed({{(VW-YW){1'b0}}, ballY_q}) + vy_q;
        absVx    = vx_q[VW-1] ? -vx_q : vx_q;
        absVy    = vy_q[VW-1] ? -vy_q : vy_q;
        boost    = (absVx + V_ONE > V_MAX) ? V_MAX : absVx + V_ONE;
        overlapL = (int'(ballY_q) + BALL_SIZE > int'(padL)) && (int'(ballY_q) < int'(padL) + PADDLE_H);
        overlapR = (int'(ballY_q) + BALL_SIZE > int'(padR)) && (int'(ballY_q) < int'(padR) + PADDLE_H);
    end

    always_comb begin
        state_d      = state_q;
        ballX_d      = ballX_q;
        ballY_d      = ballY_q;
        vx_d         = vx_q;
        vy_d         = vy_q;
        scoreL_d     = scoreL_q;
        scoreR_d     = scoreR_q;
        lastLeft_d   = lastLeft_q;
        pauseCnt_d   = pauseCnt_q;
        hitPulse_d   = 1'b0;
        pointPulse_d = 1'b0;

        if (frame_tick) begin
            case (state_q)
                SERVE: begin
                    ballX_d = X_CTR;
                    ballY_d = Y_CTR;
                    if (serve) begin
                        state_d = PLAY;
                        vy_d    = V_INIT;
                        vx_d    = lastLeft_q ? V_INIT : -V_INIT;
                    end
                end
                PLAY: begin
                    if (ny <= ZERO) begin
                        ballY_d = '0;
                        vy_d    = absVy;
                    end else if (ny >= Y_MAX) begin
                        ballY_d = Y_MAX[YW-1:0];
                        vy_d    = -absVy;
                    end else begin
                        ballY_d = ny[YW-1:0];
                    end

                    // A paddle hit takes priority over the edge test for the same tick.
                    if (vx_q[VW-1] && $signed({{(VW-XW){1'b0}}, ballX_q}) >= L_FACE &&
                        nx <= L_FACE && overlapL) begin
                        ballX_d    = L_FACE[XW-1:0];
                        vx_d       = boost;
                        hitPulse_d = 1'b1;
                    end else if (!vx_q[VW-1] && vx_q != ZERO &&
                                 $signed({{(VW-XW){1'b0}}, ballX_q}) <= R_FACE &&
                                 nx >= R_FACE && overlapR) begin
                        ballX_d    = R_FACE[XW-1:0];
                        vx_d       = -boost;
                        hitPulse_d = 1'b1;
                    end else if (nx <= ZERO) begin
                        ballX_d      = '0;
                        scoreR_d     = (scoreR_q < S_MAX) ? scoreR_q + 4'd1 : scoreR_q;
                        lastLeft_d   = 1'b0;
                        pointPulse_d = 1'b1;
                        pauseCnt_d   = '0;
                        state_d      = POINT;
                    end else if (nx >= X_MAX) begin
                        ballX_d      = X_MAX[XW-1:0];
                        scoreL_d     = (scoreL_q < S_MAX) ? scoreL_q + 4'd1 : scoreL_q;
                        lastLeft_d   = 1'b1;
                        pointPulse_d = 1'b1;
                        pauseCnt_d   = '0;
                        state_d      = POINT;
                    end else begin
                        ballX_d = nx[XW-1:0];
                    end
                end
                POINT: begin
                    if (pauseCnt_q == PAUSE_LAST) begin
                        ballX_d = X_CTR;
                        ballY_d = Y_CTR;
                        state_d = (scoreL_q == S_MAX || scoreR_q == S_MAX) ? GAME_OVER : SERVE;
                    end else begin
                        pauseCnt_d = pauseCnt_q + PW'(1);
                    end
                end
                GAME_OVER: begin
                    if (serve) begin
                        scoreL_d   = '0;
                        scoreR_d   = '0;
                        lastLeft_d = 1'b1;
                        state_d    = SERVE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state_q      <= SERVE;
            ballX_q      <= X_CTR;
            ballY_q      <= Y_CTR;
            vx_q         <= V_INIT;
            vy_q         <= V_INIT;
            scoreL_q     <= '0;
            scoreR_q     <= '0;
            lastLeft_q   <= 1'b1;
            pauseCnt_q   <= '0;
            hitPulse_q   <= 1'b0;
            pointPulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ballX_q      <= ballX_d;
            ballY_q      <= ballY_d;
            vx_q         <= vx_d;
            vy_q         <= vy_d;
            scoreL_q     <= scoreL_d;
            scoreR_q     <= scoreR_d;
            lastLeft_q   <= lastLeft_d;
            pauseCnt_q   <= pauseCnt_d;
            hitPulse_q   <= hitPulse_d;
            pointPulse_q <= pointPulse_d;
        end
    end

    assign ball_x      = ballX_q;
    assign ball_y      = ballY_q;
    assign paddle_l_y  = padL;
    assign paddle_r_y  = padR;
    assign score_l     = scoreL_q;
    assign score_r     = scoreR_q;
    assign state       = state_q;
    assign hit_pulse   = hitPulse_q;
    assign point_pulse = pointPulse_q;
    assign game_over   = (state_q == GAME_OVER);

endmodule

// File: tb/tb_pong_game_engine.sv
// Directed bench for pong_game_engine: serve, wall bounce, paddle hit, scoring, pause and game over.
module tb_pong_game_engine;

    logic       pixelClk = 1'b0;
    logic       reset, frameTick, serve, lUp, lDown, rUp, rDown;
    logic [9:0] ballX;
    logic [8:0] ballY, padL, padR;
    logic [3:0] scoreL, scoreR;
    logic [1:0] stateOut;
    logic       hitPulse, pointPulse, gameOver;

    int compared   = 0;
    int mismatched = 0;

    pong_game_engine dut (
        .pixel_clk   (pixelClk),
        .reset       (reset),
        .frame_tick  (frameTick),
        .serve       (serve),
        .l_up        (lUp),
        .l_down      (lDown),
        .r_up        (rUp),
        .r_down      (rDown),
        .ball_x      (ballX),
        .ball_y      (ballY),
        .paddle_l_y  (padL),
        .paddle_r_y  (padR),
        .score_l     (scoreL),
        .score_r     (scoreR),
        .state       (stateOut),
        .hit_pulse   (hitPulse),
        .point_pulse (pointPulse),
        .game_over   (gameOver)
    );

    always #5 pixelClk = ~pixelClk;

    // Each frame tick spans one rising edge; outputs are sampled on the following falling edge.
    task automatic applyStimulus(input int ticks);
        for (int i = 0; i < ticks; i++) begin
            @(negedge pixelClk);
            frameTick = 1'b1;
            @(negedge pixelClk);
            frameTick = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".ball_x"}, 32'(ballX), 307);
        checkOutput({tag, ".ball_y"}, 32'(ballY), 227);
        checkOutput({tag, ".pad_l"}, 32'(padL), 165);
        checkOutput({tag, ".pad_r"}, 32'(padR), 165);
        checkOutput({tag, ".score_l"}, 32'(scoreL), 0);
        checkOutput({tag, ".score_r"}, 32'(scoreR), 0);
        checkOutput({tag, ".state"}, 32'(stateOut), 0);
        checkOutput({tag, ".hit"}, 32'(hitPulse), 0);
        checkOutput({tag, ".point"}, 32'(pointPulse), 0);
        checkOutput({tag, ".game_over"}, 32'(gameOver), 0);
    endtask

    initial begin
        reset = 1'b1; frameTick = 1'b0; serve = 1'b0;
        lUp = 1'b0; lDown = 1'b0; rUp = 1'b0; rDown = 1'b0;
        repeat (3) @(negedge pixelClk);
        reset = 1'b0;
        checkResetState("reset");

        applyStimulus(5);
        checkResetState("idle5");

        serve = 1'b1;
        repeat (3) @(negedge pixelClk);
        serve = 1'b0;
        checkOutput("serve_no_tick.state", 32'(stateOut), 0);

        // Serve with right paddle held down; tick count m is measured from the serve tick.
        rDown = 1'b1;
        serve = 1'b1;
        applyStimulus(1);
        serve = 1'b0;
        checkOutput("serve.state", 32'(stateOut), 1);
        checkOutput("serve.ball_x", 32'(ballX), 307);
        checkOutput("serve.pad_r", 32'(padR), 171);
        applyStimulus(26);
        checkOutput("m26.pad_r", 32'(padR), 327);
        applyStimulus(1);
        checkOutput("m27.pad_r_clamp", 32'(padR), 330);
        applyStimulus(1);
        checkOutput("m28.pad_r_hold", 32'(padR), 330);
        applyStimulus(29);
        checkOutput("m57.ball_y_wall", 32'(ballY), 455);
        checkOutput("m57.ball_x", 32'(ballX), 535);
        applyStimulus(1);
        checkOutput("m58.ball_y_bounce", 32'(ballY), 451);
        applyStimulus(8);
        checkOutput("m66.ball_x", 32'(ballX), 571);
        checkOutput("m66.hit", 32'(hitPulse), 0);
        applyStimulus(1);
        checkOutput("m67.ball_x_face", 32'(ballX), 575);
        checkOutput("m67.hit", 32'(hitPulse), 1);
        @(negedge pixelClk);
        checkOutput("m67.hit_drop", 32'(hitPulse), 0);
        applyStimulus(1);
        checkOutput("m68.ball_x_vx5", 32'(ballX), 570);
        applyStimulus(103);
        checkOutput("m171.ball_x", 32'(ballX), 55);
        checkOutput("m171.ball_y_top", 32'(ballY), 0);
        applyStimulus(1);
        checkOutput("m172.ball_x", 32'(ballX), 50);
        checkOutput("m172.ball_y", 32'(ballY), 4);
        checkOutput("m172.no_hit", 32'(hitPulse), 0);
        applyStimulus(9);
        checkOutput("m181.ball_x", 32'(ballX), 5);
        checkOutput("m181.state", 32'(stateOut), 1);
        applyStimulus(1);
        checkOutput("m182.ball_x_edge", 32'(ballX), 0);
        checkOutput("m182.score_r", 32'(scoreR), 1);
        checkOutput("m182.point", 32'(pointPulse), 1);
        checkOutput("m182.state", 32'(stateOut), 2);

        // Paddles must hold during the pause even with a button held.
        rDown = 1'b0;
        lUp   = 1'b1;
        applyStimulus(59);
        checkOutput("pause59.state", 32'(stateOut), 2);
        checkOutput("pause59.pad_l", 32'(padL), 165);
        checkOutput("pause59.point", 32'(pointPulse), 0);
        applyStimulus(1);
        lUp = 1'b0;
        checkOutput("pause60.state", 32'(stateOut), 0);
        checkOutput("pause60.ball_x", 32'(ballX), 307);
        checkOutput("pause60.ball_y", 32'(ballY), 227);

        serve = 1'b1;
        applyStimulus(1);
        serve = 1'b0;
        applyStimulus(1);
        checkOutput("reserve_r.ball_x", 32'(ballX), 303);
        checkOutput("reserve_r.ball_y", 32'(ballY), 231);

        @(negedge pixelClk);
        reset = 1'b1;
        @(negedge pixelClk);
        reset = 1'b0;
        checkResetState("midreset");

        lUp = 1'b1; lDown = 1'b1;
        applyStimulus(10);
        checkOutput("both.pad_l", 32'(padL), 165);
        lDown = 1'b0;
        applyStimulus(27);
        checkOutput("up27.pad_l", 32'(padL), 3);
        applyStimulus(1);
        checkOutput("up28.pad_l_clamp", 32'(padL), 0);
        lUp = 1'b0;

        // Left player wins nine straight rallies; every serve heads right.
        for (int r = 1; r <= 9; r++) begin
            serve = 1'b1;
            applyStimulus(1);
            serve = 1'b0;
            applyStimulus(1);
            checkOutput("round.ball_x_m1", 32'(ballX), 311);
            applyStimulus(76);
            checkOutput("round.ball_x_edge", 32'(ballX), 615);
            checkOutput("round.score_l", 32'(scoreL), 32'(r));
            checkOutput("round.point", 32'(pointPulse), 1);
            checkOutput("round.state_point", 32'(stateOut), 2);
            @(negedge pixelClk);
            checkOutput("round.point_drop", 32'(pointPulse), 0);
            applyStimulus(60);
            checkOutput("round.state_after", 32'(stateOut), (r == 9) ? 32'd3 : 32'd0);
            checkOutput("round.game_over", 32'(gameOver), (r == 9) ? 32'd1 : 32'd0);
        end

        applyStimulus(5);
        checkOutput("over_hold.state", 32'(stateOut), 3);
        checkOutput("over_hold.score_l", 32'(scoreL), 9);
        serve = 1'b1;
        applyStimulus(1);
        serve = 1'b0;
        checkOutput("over_serve.state", 32'(stateOut), 0);
        checkOutput("over_serve.score_l", 32'(scoreL), 0);
        checkOutput("over_serve.score_r", 32'(scoreR), 0);
        checkOutput("over_serve.game_over", 32'(gameOver), 0);
        serve = 1'b1;
        applyStimulus(1);
        serve = 1'b0;
        applyStimulus(1);
        checkOutput("newgame.ball_x", 32'(ballX), 311);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
